// File: rtl/avmm_lvds_bridge_pkg.sv
// Shared definitions for both ends of the Avalon-MM over LVDS bridge:
// request header layout, command encoding and the burst length limit.
package avmm_lvds_bridge_pkg;

    // Longest burst either side may issue; also the response FIFO depth.
    localparam int MAX_BURST = 64;

    // Header word layout: {cmd, byteenable, burstcount (low bits)}.
    localparam int HDR_CMD_MSB = 31;
    localparam int HDR_CMD_LSB = 30;
    localparam int HDR_BE_MSB  = 29;
    localparam int HDR_BE_LSB  = 26;
    localparam int HDR_CNT_W   = 26;

    typedef enum logic [1:0] {
        CMD_SWR = 2'b00,  // single write
        CMD_SRD = 2'b01,  // single read
        CMD_BWR = 2'b10,  // burst write
        CMD_BRD = 2'b11   // burst read
    } cmd_t;

    typedef struct packed {
        cmd_t                 cmd;
        logic [3:0]           be;
        logic [HDR_CNT_W-1:0] cnt_field;
    } hdr_t;

    // Bit 1 of the command selects burst, bit 0 selects read.
    function automatic logic cmd_is_burst(input cmd_t c);
        return c[1];
    endfunction

    function automatic logic cmd_is_read(input cmd_t c);
        return c[0];
    endfunction

endpackage

// File: rtl/avmm_lvds_bridge_avm_if.sv
// Remote-side Avalon-MM master of the LVDS bridge. Pops request packets
// from the RX request FIFO, replays them as single or burst Avalon-MM
// transactions and pushes read data into the response TX FIFO. Writes are
// posted; only reads produce response words.
module avmm_lvds_bridge_avm_if
    import avmm_lvds_bridge_pkg::*;
#(
    parameter int BURSTCNT_W = 11,
    parameter int ADDR_W     = 19
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           req_q_i,
    input  logic                  req_rdempty_i,
    output logic                  req_rdreq_o,
    output logic [ADDR_W-1:0]     m0_address_o,
    output logic [3:0]            m0_byteenable_o,
    output logic [31:0]           m0_writedata_o,
    input  logic [31:0]           m0_readdata_i,
    output logic                  m0_write_o,
    output logic                  m0_read_o,
    input  logic                  m0_waitrequest_i,
    input  logic                  m0_readdatavalid_i,
    output logic [BURSTCNT_W-1:0] m0_burstcount_o,
    output logic [31:0]           resp_data_o,
    output logic                  resp_valid_o,
    output logic                  bad_hdr_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WR,
        ST_RD_CMD,
        ST_RD_DATA
    } state_t;

    state_t                state;
    hdr_t                  hdr;
    cmd_t                  cmd_q;
    logic [3:0]            be_q;
    logic [BURSTCNT_W-1:0] cnt_q;
    logic [BURSTCNT_W-1:0] beat_q;
    logic [BURSTCNT_W-1:0] beat_nxt;
    logic                  burst_bad;
    logic                  wr_accept;
    logic                  unused_hdr;

    assign hdr        = hdr_t'(req_q_i);
    // Header count bits above BURSTCNT_W carry no meaning on this side.
    assign unused_hdr = ^hdr;

    assign beat_nxt  = beat_q + BURSTCNT_W'(1);
    assign burst_bad = cmd_is_burst(cmd_q) &&
                       ((cnt_q == '0) || (cnt_q > BURSTCNT_W'(MAX_BURST)));
    assign wr_accept = m0_write_o && !m0_waitrequest_i;

    // FIFO pop and write strobe follow the FIFO head directly so a beat can
    // be issued in the same cycle a word shows up.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        req_rdreq_o    = 1'b0;
        m0_write_o     = 1'b0;
        m0_writedata_o = '0;
        // Held low during reset so nothing is popped or written while the
        // state register is still being cleared.
        if (!rst_i) begin
            case (state)
                ST_IDLE, ST_ADDR: begin
                    req_rdreq_o = !req_rdempty_i;
                end
                ST_WR: begin
                    m0_write_o     = !req_rdempty_i;
                    m0_writedata_o = req_q_i;
                    req_rdreq_o    = !req_rdempty_i && !m0_waitrequest_i;
                end
                default: ;
            endcase
        end
    end

    // Packet FSM: header/address decode, beat counting and registered outputs.
    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst_i) begin
            state           <= ST_IDLE;
            cmd_q           <= CMD_SWR;
            be_q            <= '0;
            cnt_q           <= '0;
            beat_q          <= '0;
            m0_address_o    <= '0;
            m0_byteenable_o <= '0;
            m0_burstcount_o <= '0;
            m0_read_o       <= 1'b0;
            resp_data_o     <= '0;
            resp_valid_o    <= 1'b0;
            bad_hdr_o       <= 1'b0;
        end else begin
            resp_valid_o <= 1'b0;
            bad_hdr_o    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!req_rdempty_i) begin
                        cmd_q  <= hdr.cmd;
                        be_q   <= hdr.be;
                        cnt_q  <= hdr.cnt_field[BURSTCNT_W-1:0];
                        beat_q <= '0;
                        state  <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (!req_rdempty_i) begin
                        if (burst_bad) begin
                            // Rejected burst: its data words (if any) are not
                            // consumed, the next word is taken as a header.
                            bad_hdr_o <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            m0_address_o <= req_q_i[ADDR_W-1:0];
                            if (cmd_is_burst(cmd_q)) begin
                                m0_byteenable_o <= 4'hF;
                                m0_burstcount_o <= cnt_q;
                            end else begin
                                m0_byteenable_o <= be_q;
                                m0_burstcount_o <= BURSTCNT_W'(1);
                            end
                            if (cmd_is_read(cmd_q)) begin
                                m0_read_o <= 1'b1;
                                state     <= ST_RD_CMD;
                            end else begin
                                state <= ST_WR;
                            end
                        end
                    end
                end
                ST_WR: begin
                    if (wr_accept) begin
                        beat_q <= beat_nxt;
                        if (beat_nxt == m0_burstcount_o) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_RD_CMD, ST_RD_DATA: begin
                    if (state == ST_RD_CMD && !m0_waitrequest_i) begin
                        m0_read_o <= 1'b0;
                        state     <= ST_RD_DATA;
                    end
                    if (m0_readdatavalid_i) begin
                        resp_data_o  <= m0_readdata_i;
                        resp_valid_o <= 1'b1;
                        beat_q       <= beat_nxt;
                        if (beat_nxt == m0_burstcount_o) begin
                            m0_read_o <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avmm_lvds_bridge_avm_if.sv
// Bench for avmm_lvds_bridge_avm_if. Stimulus fills a modelled show-ahead
// request FIFO and plays the Avalon slave; expected write beats, read
// commands and response words are queued and checked by a monitor.
module tb_avmm_lvds_bridge_avm_if;
    import avmm_lvds_bridge_pkg::*;

    localparam int BW = 11;
    localparam int AW = 19;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [31:0]   req_q_i;
    logic          req_rdempty_i;
    logic          req_rdreq_o;
    logic [AW-1:0] m0_address_o;
    logic [3:0]    m0_byteenable_o;
    logic [31:0]   m0_writedata_o;
    logic [31:0]   m0_readdata_i = '0;
    logic          m0_write_o;
    logic          m0_read_o;
    logic          m0_waitrequest_i = 1'b0;
    logic          m0_readdatavalid_i = 1'b0;
    logic [BW-1:0] m0_burstcount_o;
    logic [31:0]   resp_data_o;
    logic          resp_valid_o;
    logic          bad_hdr_o;

    avmm_lvds_bridge_avm_if #(.BURSTCNT_W(BW), .ADDR_W(AW)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .req_q_i            (req_q_i),
        .req_rdempty_i      (req_rdempty_i),
        .req_rdreq_o        (req_rdreq_o),
        .m0_address_o       (m0_address_o),
        .m0_byteenable_o    (m0_byteenable_o),
        .m0_writedata_o     (m0_writedata_o),
        .m0_readdata_i      (m0_readdata_i),
        .m0_write_o         (m0_write_o),
        .m0_read_o          (m0_read_o),
        .m0_waitrequest_i   (m0_waitrequest_i),
        .m0_readdatavalid_i (m0_readdatavalid_i),
        .m0_burstcount_o    (m0_burstcount_o),
        .resp_data_o        (resp_data_o),
        .resp_valid_o       (resp_valid_o),
        .bad_hdr_o          (bad_hdr_o)
    );

    always #5 clk_i = ~clk_i;

    // Show-ahead request FIFO model.
    logic [31:0] fifo_mem [0:255];
    int wp = 0;
    int rp = 0;
    assign req_q_i       = fifo_mem[rp[7:0]];
    assign req_rdempty_i = (wp == rp);

    always @(posedge clk_i) begin
        if (req_rdreq_o === 1'b1) rp <= rp + 1;
    end

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [BW-1:0] bc;
        logic [31:0]   data;
    } wr_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [BW-1:0] bc;
    } rd_t;

    wr_t         exp_wr[$];
    rd_t         exp_rd[$];
    logic [31:0] exp_resp[$];

    int checks = 0;
    int errors = 0;
    int bad_seen = 0;
    int read_cycles = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [127:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    // Monitor: sampled on the falling edge, mid-cycle.
    always @(negedge clk_i) begin
        if (m0_read_o === 1'b1) read_cycles++;
        if (bad_hdr_o === 1'b1) bad_seen++;
        if (req_rdempty_i)
            check("pop_or_write_while_empty", {req_rdreq_o, m0_write_o}, 2'b00);
        if (m0_write_o === 1'b1 && m0_waitrequest_i === 1'b0) begin
            if (exp_wr.size() == 0) unexpected("unexpected_write", {m0_address_o, m0_writedata_o});
            else check("write_beat", {m0_address_o, m0_byteenable_o, m0_burstcount_o, m0_writedata_o},
                       exp_wr.pop_front());
        end
        if (m0_read_o === 1'b1 && m0_waitrequest_i === 1'b0) begin
            if (exp_rd.size() == 0) unexpected("unexpected_read", {m0_address_o, m0_burstcount_o});
            else check("read_cmd", {m0_address_o, m0_byteenable_o, m0_burstcount_o}, exp_rd.pop_front());
        end
        if (resp_valid_o === 1'b1) begin
            if (exp_resp.size() == 0) unexpected("unexpected_resp", resp_data_o);
            else check("resp_word", resp_data_o, exp_resp.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        fifo_mem[wp[7:0]] = w;
        wp++;
    endtask

    function automatic logic [31:0] mk_hdr(input logic [1:0] cmd, input logic [3:0] be, input logic [BW-1:0] cnt);
        return {cmd, be, 15'd0, cnt};
    endfunction

    task automatic wait_read(input string name);
        for (int i = 0; i < 50; i++) begin
            if (m0_read_o) break;
            tick();
        end
        check(name, m0_read_o, 1'b1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_wr.size() != 0 || exp_rd.size() != 0 || exp_resp.size() != 0 || wp != rp) && n < 300) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check(name, {exp_wr.size(), exp_rd.size(), exp_resp.size(), wp - rp}, 128'd0);
    endtask

    function automatic logic [127:0] all_outs();
        return {req_rdreq_o, m0_address_o, m0_byteenable_o, m0_writedata_o, m0_write_o,
                m0_read_o, m0_burstcount_o, resp_data_o, resp_valid_o, bad_hdr_o};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int rc0;
        int rp0;
        int bad0;
        for (int i = 0; i < 256; i++) fifo_mem[i] = '0;

        // Reset state
        repeat (2) tick();
        check("reset_outputs", all_outs(), 128'd0);
        rst_i = 1'b0;
        tick();

        // 1: single write, header byteenable kept, burstcount forced to 1
        push(mk_hdr(2'b00, 4'h3, 11'd0));
        push(32'h0000_0100);
        push(32'hDEAD_BEEF);
        exp_wr.push_back('{addr: 19'h00100, be: 4'h3, bc: 11'd1, data: 32'hDEAD_BEEF});
        drain("t1_single_write");

        // 2: single read stalled by 3 waitrequests
        m0_waitrequest_i = 1'b1;
        rc0 = read_cycles;
        push(mk_hdr(2'b01, 4'hA, 11'd0));
        push(32'h0007_FFFF);
        exp_rd.push_back('{addr: 19'h7FFFF, be: 4'hA, bc: 11'd1});
        exp_resp.push_back(32'h1234_5678);
        wait_read("t2_read_start");
        repeat (3) tick();
        m0_waitrequest_i = 1'b0;
        tick();
        m0_readdatavalid_i = 1'b1;
        m0_readdata_i      = 32'h1234_5678;
        tick();
        m0_readdatavalid_i = 1'b0;
        drain("t2_single_read");
        check("t2_read_held_cycles", read_cycles - rc0, 4);

        // 3: burst write of 4 with FIFO gaps and a stall
        push(mk_hdr(2'b10, 4'h0, 11'd4));
        push(32'h0001_2340);
        for (int i = 1; i <= 4; i++)
            exp_wr.push_back('{addr: 19'h12340, be: 4'hF, bc: 11'd4, data: 32'h1111_1111 * i});
        push(32'h1111_1111);
        repeat (3) tick();
        push(32'h2222_2222);
        tick();
        m0_waitrequest_i = 1'b1;
        push(32'h3333_3333);
        repeat (2) tick();
        m0_waitrequest_i = 1'b0;
        repeat (2) tick();
        push(32'h4444_4444);
        drain("t3_burst_write");

        // 4: burst read of 8 with bubbles; next packet waits until done
        push(mk_hdr(2'b11, 4'h0, 11'd8));
        push(32'h0000_0040);
        exp_rd.push_back('{addr: 19'h00040, be: 4'hF, bc: 11'd8});
        wait_read("t4_read_start");
        tick();
        push(mk_hdr(2'b00, 4'hC, 11'd0));
        push(32'h0000_0055);
        push(32'hCAFE_F00D);
        exp_wr.push_back('{addr: 19'h00055, be: 4'hC, bc: 11'd1, data: 32'hCAFE_F00D});
        rp0 = rp;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("t4_no_pop_during_read", rp, rp0);
            m0_readdatavalid_i = 1'b1;
            m0_readdata_i      = 32'hA500_0000 + i;
            exp_resp.push_back(32'hA500_0000 + i);
            tick();
            if (i % 3 == 1) begin
                m0_readdatavalid_i = 1'b0;
                tick();
            end
        end
        m0_readdatavalid_i = 1'b0;
        drain("t4_burst_read");

        // 5: bad burst headers (count 0 and MAX_BURST+1), then a valid read
        bad0 = bad_seen;
        push(mk_hdr(2'b10, 4'h0, 11'd0));
        push(32'h0000_0011);
        push(mk_hdr(2'b11, 4'h0, BW'(MAX_BURST + 1)));
        push(32'h0000_0022);
        push(mk_hdr(2'b01, 4'h6, 11'd0));
        push(32'h0000_0033);
        exp_rd.push_back('{addr: 19'h00033, be: 4'h6, bc: 11'd1});
        exp_resp.push_back(32'h0BAD_F00D);
        wait_read("t5_read_start");
        tick();
        m0_readdatavalid_i = 1'b1;
        m0_readdata_i      = 32'h0BAD_F00D;
        tick();
        m0_readdatavalid_i = 1'b0;
        drain("t5_bad_headers");
        check("t5_bad_pulses", bad_seen - bad0, 2);

        // 6: reset during beat 3 of an 8-beat burst read
        push(mk_hdr(2'b11, 4'h0, 11'd8));
        push(32'h0000_0777);
        exp_rd.push_back('{addr: 19'h00777, be: 4'hF, bc: 11'd8});
        wait_read("t6_read_start");
        tick();
        for (int i = 0; i < 3; i++) begin
            m0_readdatavalid_i = 1'b1;
            m0_readdata_i      = 32'hB000_0000 + i;
            exp_resp.push_back(32'hB000_0000 + i);
            tick();
        end
        rst_i         = 1'b1;
        m0_readdata_i = 32'hDEAD_0003;
        tick();
        rst_i = 1'b0;
        check("t6_outputs_after_reset", all_outs(), 128'd0);
        tick();
        m0_readdatavalid_i = 1'b0;
        tick();
        drain("t6_reset_mid_burst");

        // Recovery: a normal single write after the reset
        push(mk_hdr(2'b00, 4'h1, 11'd0));
        push(32'h0000_0005);
        push(32'h0F0F_0F0F);
        exp_wr.push_back('{addr: 19'h00005, be: 4'h1, bc: 11'd1, data: 32'h0F0F_0F0F});
        drain("t6_recovery_write");
        check("bad_total", bad_seen, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
